// File: rtl/drp_port_arbiter_pkg.sv
// Shared types and constants for the DRP port arbiter: FSM encoding, DRP bus
// widths, latched request payload and the data returned on an aborted access.
package drp_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned GNT_W  = 2;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } drp_req_t;

  // Requester index reduced modulo the number of requesters.
  function automatic logic [GNT_W-1:0] wrap_idx(input int unsigned idx,
                                                input int unsigned n);
    return GNT_W'(idx % n);
  endfunction

endpackage

// File: rtl/drp_port_arbiter_rr_select.sv
// Round-robin pick: the first set request found searching upward from the
// requester after last_i, wrapping around.
module rr_select
  import drp_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GNT_W-1:0]   last_i,
  output logic [GNT_W-1:0]   gnt_o,
  output logic               valid_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;

  // Bit j of req_rot is requester (last_i + 1 + j) mod NUM_REQ.
  assign req_dbl = {req_i, req_i};
  assign req_rot = NUM_REQ'(req_dbl >> (32'(last_i) + 32'd1));

  // Walk downward so the lowest rotated offset is the one left standing.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if ((req_rot & (NUM_REQ'(1) << j)) != '0) begin
        valid_o = 1'b1;
        gnt_o   = wrap_idx(32'(last_i) + 32'd1 + 32'(j), NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/drp_port_arbiter.sv
// Shares one GTP DRP port between NUM_REQ requesters: round-robin grant,
// single-cycle den, drdy completion or timeout abort, then a release cycle.
module drp_port_arbiter
  import drp_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_den,
  input  logic [NUM_REQ-1:0]        req_dwe,
  input  logic [ADDR_W*NUM_REQ-1:0] req_daddr,
  input  logic [DATA_W*NUM_REQ-1:0] req_di,
  output logic [DATA_W-1:0]         req_do,
  output logic [NUM_REQ-1:0]        req_drdy,
  output logic [NUM_REQ-1:0]        req_timeout,
  output logic [ADDR_W-1:0]         daddr,
  output logic                      den,
  output logic                      dwe,
  output logic [DATA_W-1:0]         di,
  input  logic [DATA_W-1:0]         do_i,
  input  logic                      drdy,
  output logic                      busy,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      stray_drdy
);

  // Counter only has to hold 0 .. TIMEOUT_CYC-1; reaching the last value
  // without drdy is the abort point.
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e               state_q;
  logic [GNT_W-1:0]     last_q;
  logic [GNT_W-1:0]     grant_id_q;
  drp_req_t             req_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 den_q;
  logic                 dwe_q;
  logic [DATA_W-1:0]    req_do_q;
  logic [NUM_REQ-1:0]   req_drdy_q;
  logic [NUM_REQ-1:0]   req_timeout_q;
  logic                 busy_q;
  logic                 stray_q;

  logic [GNT_W-1:0]     sel_gnt;
  logic                 sel_valid;
  drp_req_t             sel_req;
  logic [NUM_REQ-1:0]   gnt_oh;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req_i   (req_den),
    .last_i  (last_q),
    .gnt_o   (sel_gnt),
    .valid_o (sel_valid)
  );

  // Payload of the requester that would win this cycle.
  always_comb begin
    sel_req      = '0;
    sel_req.we   = |(req_dwe & (NUM_REQ'(1) << sel_gnt));
    sel_req.addr = ADDR_W'(req_daddr >> (32'(sel_gnt) * ADDR_W));
    sel_req.data = DATA_W'(req_di >> (32'(sel_gnt) * DATA_W));
  end

  // Completion pulses go only to a grantee still holding its request.
  assign gnt_oh = NUM_REQ'(1) << grant_id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_q        <= GNT_W'(NUM_REQ - 1);
      grant_id_q    <= '0;
      req_q         <= '0;
      cnt_q         <= '0;
      den_q         <= 1'b0;
      dwe_q         <= 1'b0;
      req_do_q      <= '0;
      req_drdy_q    <= '0;
      req_timeout_q <= '0;
      busy_q        <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      den_q         <= 1'b0;
      dwe_q         <= 1'b0;
      req_drdy_q    <= '0;
      req_timeout_q <= '0;

      if (drdy && (state_q != ST_WAIT)) begin
        stray_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (sel_valid) begin
            req_q      <= sel_req;
            grant_id_q <= sel_gnt;
            last_q     <= sel_gnt;
            den_q      <= 1'b1;
            dwe_q      <= sel_req.we;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end

        // drdy takes priority over a timeout landing on the same cycle.
        ST_WAIT: begin
          if (drdy) begin
            req_do_q   <= req_q.we ? '0 : do_i;
            req_drdy_q <= req_den & gnt_oh;
            cnt_q      <= '0;
            state_q    <= ST_RELEASE;
          end else if (cnt_q == CNT_LAST) begin
            req_do_q      <= TIMEOUT_DATA;
            req_drdy_q    <= req_den & gnt_oh;
            req_timeout_q <= req_den & gnt_oh;
            cnt_q         <= '0;
            state_q       <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_do      = req_do_q;
  assign req_drdy    = req_drdy_q;
  assign req_timeout = req_timeout_q;
  assign daddr       = req_q.addr;
  assign di          = req_q.data;
  assign den         = den_q;
  assign dwe         = dwe_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign stray_drdy  = stray_q;

endmodule

// File: tb/tb_drp_port_arbiter.sv
// Directed bench for drp_port_arbiter: reads, writes, contention, early
// request drop, timeout and its drdy boundary, and reset during WAIT.
module tb_drp_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_den;
  logic [1:0]  req_dwe;
  logic [13:0] req_daddr;
  logic [31:0] req_di;
  logic [15:0] req_do;
  logic [1:0]  req_drdy;
  logic [1:0]  req_timeout;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] do_r;
  logic        drdy;
  logic        busy;
  logic [1:0]  grant_id;
  logic        stray_drdy;

  int checks   = 0;
  int failures = 0;
  int n_wait;
  int lat;

  always #5 clk = ~clk;

  drp_port_arbiter #(
    .NUM_REQ     (2),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_den     (req_den),
    .req_dwe     (req_dwe),
    .req_daddr   (req_daddr),
    .req_di      (req_di),
    .req_do      (req_do),
    .req_drdy    (req_drdy),
    .req_timeout (req_timeout),
    .daddr       (daddr),
    .den         (den),
    .dwe         (dwe),
    .di          (di),
    .do_i        (do_r),
    .drdy        (drdy),
    .busy        (busy),
    .grant_id    (grant_id),
    .stray_drdy  (stray_drdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_den = 2'b00;
    req_dwe = 2'b00;
    drdy    = 1'b0;
    do_r    = 16'h0000;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for den, check the issued access, answer with drdy k cycles after
  // den, then check the completion one cycle later.
  task automatic serve(input string tag, input int k, input logic [15:0] rdata,
                       input logic [1:0] exp_gid, input logic exp_we,
                       input logic [6:0] exp_addr, input logic [15:0] exp_di,
                       input logic [1:0] exp_oh, input logic [15:0] exp_rdo,
                       input bit chk_rdo, input bit drop, output int n);
    n = 0;
    while (den !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_den"}, 32'(den), 32'd1);
    chk({tag, "_gid"}, 32'(grant_id), 32'(exp_gid));
    chk({tag, "_addr"}, 32'(daddr), 32'(exp_addr));
    chk({tag, "_dwe"}, 32'(dwe), 32'(exp_we));
    if (exp_we) chk({tag, "_di"}, 32'(di), 32'(exp_di));
    if (drop) req_den = 2'b00;
    @(negedge clk);
    chk({tag, "_den_single"}, {30'd0, den, dwe}, 32'd0);
    repeat (k - 1) @(negedge clk);
    chk({tag, "_early"}, 32'(req_drdy), 32'd0);
    drdy = 1'b1;
    do_r = rdata;
    @(negedge clk);
    drdy = 1'b0;
    do_r = 16'h0000;
    chk({tag, "_drdy"}, 32'(req_drdy), 32'(exp_oh));
    chk({tag, "_tmo"}, 32'(req_timeout), 32'd0);
    if (chk_rdo) chk({tag, "_rdo"}, 32'(req_do), 32'(exp_rdo));
  endtask

  initial begin
    req_daddr = 14'd0;
    req_di    = 32'd0;
    do_reset();
    chk("rst_outputs", {16'd0, 7'd0, daddr, den, dwe, busy}, 32'd0);
    chk("rst_misc", {24'd0, grant_id, req_drdy, req_timeout, stray_drdy, 1'b0}, 32'd0);
    chk("rst_data", {req_do, di}, 32'd0);

    // Single read at 0x46, drdy three cycles after den.
    req_daddr = {7'h00, 7'h46};
    req_den   = 2'b01;
    serve("rd", 3, 16'h1234, 2'd0, 1'b0, 7'h46, 16'h0, 2'b01, 16'h1234, 1'b1, 1'b0, n_wait);
    chk("rd_req_to_den", 32'(n_wait), 32'd1);
    chk("rd_busy_release", 32'(busy), 32'd1);
    req_den = 2'b00;
    @(negedge clk);
    chk("rd_busy_idle", 32'(busy), 32'd0);
    chk("rd_no_stray", 32'(stray_drdy), 32'd0);
    chk("rd_drdy_once", 32'(req_drdy), 32'd0);

    // Both requesters held from reset: 0, 1, 0, 1.
    do_reset();
    req_daddr = {7'h20, 7'h10};
    req_den   = 2'b11;
    serve("c0", 1, 16'h0A0A, 2'd0, 1'b0, 7'h10, 16'h0, 2'b01, 16'h0A0A, 1'b1, 1'b0, n_wait);
    chk("c0_wait", 32'(n_wait), 32'd1);
    serve("c1", 1, 16'h0B0B, 2'd1, 1'b0, 7'h20, 16'h0, 2'b10, 16'h0B0B, 1'b1, 1'b0, n_wait);
    chk("c1_gap", 32'(n_wait), 32'd2);
    serve("c2", 2, 16'h0C0C, 2'd0, 1'b0, 7'h10, 16'h0, 2'b01, 16'h0C0C, 1'b1, 1'b0, n_wait);
    chk("c2_gap", 32'(n_wait), 32'd2);
    serve("c3", 1, 16'h0D0D, 2'd1, 1'b0, 7'h20, 16'h0, 2'b10, 16'h0D0D, 1'b1, 1'b0, n_wait);
    chk("c3_gap", 32'(n_wait), 32'd2);
    req_den = 2'b00;
    repeat (2) @(negedge clk);

    // Requester 1 writes 0x8004 to 0x45; read bus noise must not leak out.
    do_reset();
    req_daddr = {7'h45, 7'h11};
    req_di    = {16'h8004, 16'h1111};
    req_dwe   = 2'b10;
    req_den   = 2'b10;
    serve("wr", 2, 16'hBEEF, 2'd1, 1'b1, 7'h45, 16'h8004, 2'b10, 16'h0000, 1'b1, 1'b0, n_wait);
    req_den = 2'b00;
    req_dwe = 2'b00;
    repeat (2) @(negedge clk);
    chk("wr_idle", {30'd0, busy, dwe}, 32'd0);

    // Requester drops its request mid-transaction: port finishes, no pulse.
    do_reset();
    req_daddr = {7'h00, 7'h22};
    req_den   = 2'b01;
    serve("drop", 2, 16'hCAFE, 2'd0, 1'b0, 7'h22, 16'h0, 2'b00, 16'h0, 1'b0, 1'b1, n_wait);
    chk("drop_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("drop_idle", 32'(busy), 32'd0);

    // drdy on the very cycle the counter would hit 255: data wins.
    do_reset();
    req_daddr = {7'h00, 7'h33};
    req_den   = 2'b01;
    serve("bnd", 255, 16'h5A5A, 2'd0, 1'b0, 7'h33, 16'h0, 2'b01, 16'h5A5A, 1'b1, 1'b0, n_wait);
    req_den = 2'b00;
    repeat (2) @(negedge clk);

    // No drdy at all: abort 255 cycles after entering WAIT.
    do_reset();
    req_daddr = {7'h00, 7'h3C};
    req_den   = 2'b01;
    n_wait = 0;
    while (den !== 1'b1 && n_wait < 20) begin
      @(negedge clk);
      n_wait++;
    end
    chk("to_den", 32'(den), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (req_drdy == 2'b00 && lat < 300);
    chk("to_latency", 32'(lat), 32'd256);
    chk("to_flags", {28'd0, req_drdy, req_timeout}, {28'd0, 2'b01, 2'b01});
    chk("to_rdo", 32'(req_do), 32'h0000FFFF);
    req_den = 2'b00;
    @(negedge clk);
    chk("to_idle", {29'd0, busy, req_timeout}, 32'd0);
    chk("to_no_stray", 32'(stray_drdy), 32'd0);

    // Reset while waiting on drdy; the late drdy is only a stray.
    do_reset();
    req_daddr = {7'h00, 7'h05};
    req_den   = 2'b01;
    n_wait = 0;
    while (den !== 1'b1 && n_wait < 20) begin
      @(negedge clk);
      n_wait++;
    end
    repeat (2) @(negedge clk);
    chk("rw_busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    req_den = 2'b00;
    drdy    = 1'b1;
    do_r    = 16'h7777;
    @(negedge clk);
    drdy = 1'b0;
    chk("rw_no_drdy", 32'(req_drdy), 32'd0);
    chk("rw_stray", 32'(stray_drdy), 32'd1);
    chk("rw_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("rw_stray_sticky", {30'd0, stray_drdy, |req_drdy}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drp_port_arbiter.md
DRP_PORT_ARBITER -- requirements
Module: drp_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of DRP requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, number of WAIT cycles without drdy before the transaction is aborted.
REQ-003 SHALL have port clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_den  input  NUM_REQ  per-requester request level, held until its req_drdy.
REQ-006 SHALL have port req_dwe  input  NUM_REQ  per-requester write flag (1 = write, 0 = read).
REQ-007 SHALL have port req_daddr  input  7*NUM_REQ  per-requester address; requester i occupies slice [7i+6:7i].
REQ-008 SHALL have port req_di  input  16*NUM_REQ  per-requester write data; requester i occupies slice [16i+15:16i].
REQ-009 SHALL have port req_do  output  16  read data broadcast to all requesters, valid with req_drdy.
REQ-010 SHALL have port req_drdy  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port req_timeout  output  NUM_REQ  one-cycle pulse, coincident with req_drdy, flagging an aborted transaction.
REQ-012 SHALL have port daddr  output  7  DRP address to the GTP.
REQ-013 SHALL have port den  output  1  DRP enable, single-cycle.
REQ-014 SHALL have port dwe  output  1  DRP write enable, asserted only together with den.
REQ-015 SHALL have port di  output  16  DRP write data.
REQ-016 SHALL have port do  input  16  DRP read data.
REQ-017 SHALL have port drdy  input  1  DRP ready.
REQ-018 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-019 SHALL have port grant_id  output  2  index of the current or most recent grant.
REQ-020 SHALL have port stray_drdy  output  1  sticky flag set by a drdy outside WAIT; cleared only by reset.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT and RELEASE.
REQ-022 IDLE: if any req_den bit is set, the arbiter SHALL register the winner's index, dwe, daddr and di, then go to ISSUE; otherwise it stays in IDLE.
REQ-023 Arbitration SHALL be round-robin, searching from (last grant + 1) mod NUM_REQ; after reset requester 0 has highest priority.
REQ-024 ISSUE: the arbiter SHALL drive den=1 for exactly one cycle, with dwe, daddr and di taken from the latched values, then go to WAIT.
REQ-025 WAIT: on drdy the arbiter SHALL capture do, pulse req_drdy[grant] for one cycle with req_do=captured do (0x0000 for writes), then go to RELEASE.
REQ-026 Latency SHALL be: request seen in IDLE at cycle t -> den at t+1 -> drdy at t+1+k -> req_drdy at t+2+k.
REQ-027 WAIT: the cycle counter SHALL increment each cycle without drdy; when it reaches TIMEOUT_CYC the arbiter SHALL pulse req_drdy and req_timeout for the grant, with req_do=0xFFFF, then go to RELEASE.
REQ-028 If drdy arrives in the same cycle the counter reaches TIMEOUT_CYC, drdy SHALL win and no timeout is flagged.
REQ-029 RELEASE SHALL last one cycle and then return to IDLE, giving the requester time to drop req_den before re-arbitration.
REQ-030 If the granted requester drops req_den before completion, the port transaction SHALL still finish and its req_drdy SHALL be suppressed.
REQ-031 A drdy seen in IDLE, ISSUE or RELEASE SHALL be ignored apart from setting stray_drdy.
REQ-032 Outside ISSUE, den and dwe SHALL be 0; daddr and di SHALL hold their last values.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 On reset: state=IDLE; den=0; dwe=0; daddr=0; di=0; req_do=0; req_drdy=0; req_timeout=0; busy=0; grant_id=0; stray_drdy=0; round-robin pointer=NUM_REQ-1; timeout counter=0.
REQ-035 A reset asserted mid-transaction SHALL abort it immediately, with no req_drdy; any late drdy after reset SHALL set stray_drdy.

Structure
REQ-036 The shared package SHALL hold the state encoding, the DRP address and data widths (7, 16) and the timeout data value 0xFFFF.
REQ-037 Round-robin selection SHALL be implemented as one sub-module, rr_select (request vector plus last grant in, grant index plus valid out).

Verification
REQ-038 Single read: req_den[0]=1, dwe=0, addr 0x46; drdy 3 cycles after den with do=0x1234 -> exactly one den pulse, addr 0x46, req_drdy[0] at t+5, req_do=0x1234.
REQ-039 Contention: req_den=2'b11 from reset, held -> grants occur in the order 0, 1, 0, 1; each den is separated by at least 3 cycles.
REQ-040 Write: requester 1 writes 0x8004 to 0x45 -> den=1, dwe=1, di=0x8004 for one cycle; req_drdy[1] with req_do=0x0000.
REQ-041 Timeout: drdy never asserted, TIMEOUT_CYC=255 -> req_drdy and req_timeout pulse together 255 cycles after entering WAIT, req_do=0xFFFF, then IDLE.
REQ-042 Boundary: drdy on the same cycle the counter reaches 255 -> req_timeout=0 and do is returned.
REQ-043 Reset during WAIT, then drdy arrives -> no req_drdy, stray_drdy=1, busy=0.
